// File: rtl/inst_cache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   - FSM state encodings (legacy-compatible constants)
//   - AXI read-channel constants used by the refill master
//   - helper for sizing index fields that must be at least one bit wide
package cache_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Width of an index over n items, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inst_cache_assoc_if.sv
// AXI read-address / read-data channel bundle between the cache (master)
// and the memory system (slave). No write channels exist.
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//       arvalid (master out), arready (slave out)
//   R : rid, rdata, rresp, rlast, rvalid (slave out), rready (master out)
interface inst_cache_assoc_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/inst_cache_assoc_way.sv
// One way of the instruction cache: per-set valid bit, tag and line data.
//   clk, rst       : clock, synchronous active-high reset (clears valid bits)
//   i_flush        : clear every valid bit
//   i_rd_set/word  : combinational read port (valid, tag, data word)
//   i_wr_set/word  : refill write location
//   i_tag_we       : write tag of i_wr_set and drop its valid bit
//   i_data_we      : write one data word
//   i_set_valid    : mark i_wr_set valid (flush/reset take priority)
module inst_cache_way #(
   parameter int TAG_W     = 20,
   parameter int SET_WIDTH = 6,
   parameter int WORD_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic [SET_WIDTH-1:0] i_rd_set,
   input  logic [WORD_W-1:0]    i_rd_word,
   output logic                 o_valid,
   output logic [TAG_W-1:0]     o_tag,
   output logic [31:0]          o_data,
   input  logic [SET_WIDTH-1:0] i_wr_set,
   input  logic [WORD_W-1:0]    i_wr_word,
   input  logic                 i_tag_we,
   input  logic                 i_data_we,
   input  logic                 i_set_valid,
   input  logic [TAG_W-1:0]     i_wr_tag,
   input  logic [31:0]          i_wr_data
);

   localparam int SETS  = 1 << SET_WIDTH;
   localparam int DEPTH = 1 << (SET_WIDTH + WORD_W);

   logic [SETS-1:0]  r_valid;
   logic [TAG_W-1:0] r_tag  [SETS];
   logic [31:0]      r_data [DEPTH];

   // Rewriting the tag invalidates the line so an evicted line can never
   // be seen half-overwritten if the refill is later abandoned.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_valid <= '0;
      end else if (i_tag_we) begin
         r_valid[i_wr_set] <= 1'b0;
      end else if (i_set_valid) begin
         r_valid[i_wr_set] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_tag_we) begin
         r_tag[i_wr_set] <= i_wr_tag;
      end
      if (i_data_we) begin
         r_data[{i_wr_set, i_wr_word}] <= i_wr_data;
      end
   end

   assign o_valid = r_valid[i_rd_set];
   assign o_tag   = r_tag[i_rd_set];
   assign o_data  = r_data[{i_rd_set, i_rd_word}];

endmodule

// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache with zero-latency hits and AXI burst
// refill; uncached fetches bypass the arrays with a single-beat read.
//   clk, rst          : clock, synchronous active-high reset
//   read_en, addr     : fetch request (held until ready)
//   uncached          : bypass arrays for this fetch
//   flush             : invalidate every line
//   ready, data_out   : fetched word valid / value
//   error             : bus error reported for this fetch
//   axi (master)      : AXI read channels towards memory
module inst_cache_assoc
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 6,
   parameter int SET_WIDTH  = 6,
   parameter int WAY_COUNT  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en,
   input  logic                  uncached,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  ready,
   output logic [31:0]           data_out,
   output logic                  error,
   inst_cache_assoc_if.master    axi
);

   localparam int WORD_W = LINE_WIDTH - 2;
   localparam int WORDS  = 1 << WORD_W;
   localparam int SETS   = 1 << SET_WIDTH;
   localparam int TAG_W  = ADDR_WIDTH - LINE_WIDTH - SET_WIDTH;
   localparam int WAY_W  = clog2_min1(WAY_COUNT);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:2] r_addr;
   logic                  r_unc;
   logic [7:0]            r_arlen;
   logic [WORD_W-1:0]     r_beat;
   logic                  r_err;
   logic                  r_flushed;
   logic [WAY_W-1:0]      r_victim;
   logic [31:0]           r_cap;
   logic [WAY_W-1:0]      r_rr [SETS];

   logic [TAG_W-1:0]      w_tag;
   logic [SET_WIDTH-1:0]  w_set;
   logic [WORD_W-1:0]     w_word;
   logic [TAG_W-1:0]      w_r_tag;
   logic [SET_WIDTH-1:0]  w_r_set;
   logic [WAY_COUNT-1:0]  w_way_valid;
   logic [TAG_W-1:0]      w_way_tag  [WAY_COUNT];
   logic [31:0]           w_way_data [WAY_COUNT];
   logic                  w_hit;
   logic [31:0]           w_hit_data;
   logic [WAY_W-1:0]      w_victim;
   logic                  w_found;
   logic [WAY_W-1:0]      w_rr_next;
   logic                  w_beat_we;
   logic                  w_tag_we;
   logic                  w_set_valid;
   logic                  w_idle_hit;
   logic                  w_unused_bits;

   assign w_tag   = addr[ADDR_WIDTH-1:LINE_WIDTH+SET_WIDTH];
   assign w_set   = addr[LINE_WIDTH+SET_WIDTH-1:LINE_WIDTH];
   assign w_word  = addr[LINE_WIDTH-1:2];
   assign w_r_tag = r_addr[ADDR_WIDTH-1:LINE_WIDTH+SET_WIDTH];
   assign w_r_set = r_addr[LINE_WIDTH+SET_WIDTH-1:LINE_WIDTH];

   assign w_unused_bits = ^{axi.rid, addr[1:0]};

   // Refill writes target the victim latched at miss time.
   assign w_beat_we   = (r_state == ST_DATA) && axi.rvalid && !r_unc && !rst;
   assign w_tag_we    = w_beat_we && (r_beat == '0);
   assign w_set_valid = (r_state == ST_DONE) && !r_unc && !r_err &&
                        !r_flushed && !flush;

   for (genvar g = 0; g < WAY_COUNT; g++) begin : g_way
      inst_cache_way #(
         .TAG_W    (TAG_W),
         .SET_WIDTH(SET_WIDTH),
         .WORD_W   (WORD_W)
      ) u_way (
         .clk        (clk),
         .rst        (rst),
         .i_flush    (flush),
         .i_rd_set   (w_set),
         .i_rd_word  (w_word),
         .o_valid    (w_way_valid[g]),
         .o_tag      (w_way_tag[g]),
         .o_data     (w_way_data[g]),
         .i_wr_set   (w_r_set),
         .i_wr_word  (r_beat),
         .i_tag_we   (w_tag_we && (r_victim == WAY_W'(g))),
         .i_data_we  (w_beat_we && (r_victim == WAY_W'(g))),
         .i_set_valid(w_set_valid && (r_victim == WAY_W'(g))),
         .i_wr_tag   (w_r_tag),
         .i_wr_data  (axi.rdata)
      );
   end

   // At most one way matches, so OR-ing the matching words selects it.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      for (int unsigned i = 0; i < WAY_COUNT; i++) begin
         if (w_way_valid[i] && (w_way_tag[i] == w_tag)) begin
            w_hit      = 1'b1;
            w_hit_data = w_hit_data | w_way_data[i];
         end
      end
   end

   always_comb begin
      w_victim = r_rr[w_set];
      w_found  = 1'b0;
      for (int unsigned i = 0; i < WAY_COUNT; i++) begin
         if (!w_way_valid[i] && !w_found) begin
            w_victim = WAY_W'(i);
            w_found  = 1'b1;
         end
      end
   end

   always_comb begin
      if (int'(r_rr[w_r_set]) == WAY_COUNT - 1) begin
         w_rr_next = '0;
      end else begin
         w_rr_next = r_rr[w_r_set] + 1'b1;
      end
   end

   assign w_idle_hit = (r_state == ST_IDLE) && read_en && !uncached && w_hit;
   assign ready      = w_idle_hit || ((r_state == ST_DONE) && (r_unc || r_err));
   assign error      = (r_state == ST_DONE) && r_err;

   always_comb begin
      data_out = '0;
      if (w_idle_hit) begin
         data_out = w_hit_data;
      end else if ((r_state == ST_DONE) && r_unc && !r_err) begin
         data_out = r_cap;
      end
   end

   assign axi.arid    = '0;
   assign axi.araddr  = 32'(r_unc ? {r_addr, 2'b00}
                                  : {r_addr[ADDR_WIDTH-1:LINE_WIDTH], {LINE_WIDTH{1'b0}}});
   assign axi.arlen   = r_arlen;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = '0;
   assign axi.arcache = '0;
   assign axi.arprot  = '0;
   assign axi.arvalid = (r_state == ST_ADDR);
   assign axi.rready  = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_unc     <= 1'b0;
         r_arlen   <= '0;
         r_beat    <= '0;
         r_err     <= 1'b0;
         r_flushed <= 1'b0;
         r_victim  <= '0;
         r_cap     <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            r_rr[s] <= '0;
         end
      end else begin
         // A flush during a refill must keep that line from being validated.
         if (flush && (r_state != ST_IDLE)) begin
            r_flushed <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (read_en && (uncached || !w_hit)) begin
                  r_state   <= ST_ADDR;
                  r_addr    <= addr[ADDR_WIDTH-1:2];
                  r_unc     <= uncached;
                  r_arlen   <= uncached ? 8'd0 : 8'(WORDS - 1);
                  r_beat    <= '0;
                  r_err     <= 1'b0;
                  r_flushed <= 1'b0;
                  r_victim  <= w_victim;
               end
            end
            ST_ADDR: begin
               if (axi.arready) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (axi.rvalid) begin
                  r_beat <= r_beat + 1'b1;
                  if (axi.rresp != AXI_RESP_OKAY) begin
                     r_err <= 1'b1;
                  end
                  if (axi.rlast) begin
                     r_cap   <= axi.rdata;
                     r_state <= ST_DONE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               if (!r_unc && !r_err) begin
                  r_rr[w_r_set] <= w_rr_next;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Directed, table-driven bench for inst_cache_assoc (default parameters).
module tb_inst_cache_assoc;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_en;
   logic        uncached;
   logic        flush;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] data_out;
   logic        error;

   always #5 clk = ~clk;

   inst_cache_assoc_if axi ();

   inst_cache_assoc #(
      .ADDR_WIDTH(32),
      .LINE_WIDTH(6),
      .SET_WIDTH (6),
      .WAY_COUNT (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .read_en (read_en),
      .uncached(uncached),
      .flush   (flush),
      .addr    (addr),
      .ready   (ready),
      .data_out(data_out),
      .error   (error),
      .axi     (axi)
   );

   typedef struct {
      string       name;
      bit          do_rst;
      logic [31:0] a;
      bit          unc;
      logic [31:0] base;
      int          err_beat;
      int          flush_beat;
      logic        exp_err;
      logic [31:0] exp_data;
      int          exp_ars;
      logic [31:0] exp_araddr;
      logic [7:0]  exp_arlen;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input string n, input bit r, input logic [31:0] a,
                               input bit u, input logic [31:0] b, input int eb,
                               input int fb, input logic ee, input logic [31:0] ed,
                               input int ea, input logic [31:0] ead,
                               input logic [7:0] el);
      vec_t v;
      v.name = n; v.do_rst = r; v.a = a; v.unc = u; v.base = b;
      v.err_beat = eb; v.flush_beat = fb; v.exp_err = ee; v.exp_data = ed;
      v.exp_ars = ea; v.exp_araddr = ead; v.exp_arlen = el;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_bus();
      axi.arready = 1'b0;
      axi.rid     = '0;
      axi.rdata   = '0;
      axi.rresp   = '0;
      axi.rlast   = 1'b0;
      axi.rvalid  = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1; read_en = 1'b0; uncached = 1'b0; addr = '0;
      clear_bus();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drive_beat(input logic [31:0] base, input int beat, input int len,
                             input int err_beat, input bit do_flush);
      axi.rvalid = 1'b1;
      axi.rdata  = base + 32'(beat);
      axi.rlast  = (beat == len);
      axi.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
      flush      = do_flush;
   endtask

   // Issue one fetch and act as the AXI memory until ready is seen.
   task automatic fetch(input logic [31:0] a, input bit unc, input logic [31:0] base,
                        input int err_beat, input int flush_beat,
                        output logic got, output logic [31:0] d, output logic e,
                        output int lat, output int ars, output logic [31:0] ar_a,
                        output logic [7:0] ar_len, output logic [2:0] ar_size,
                        output logic [1:0] ar_burst, output logic fixed_ok);
      int phase = 0;
      int beat  = 0;
      int len   = 0;
      got = 1'b0; d = '0; e = 1'b0; lat = 0; ars = 0; ar_a = '0; ar_len = '0;
      ar_size = '0; ar_burst = '0; fixed_ok = 1'b1;
      @(posedge clk); #1;
      read_en = 1'b1; addr = a; uncached = unc;
      for (int cyc = 0; cyc < 200 && !got; cyc++) begin
         @(negedge clk);
         if (ready) begin
            got = 1'b1; d = data_out; e = error;
         end else begin
            lat++;
            if (phase == 0) begin
               if (axi.arvalid) begin
                  ars++;
                  ar_a = axi.araddr; ar_len = axi.arlen;
                  ar_size = axi.arsize; ar_burst = axi.arburst;
                  fixed_ok = fixed_ok && (axi.arid == 4'd0) && (axi.arlock == 2'd0) &&
                             (axi.arcache == 4'd0) && (axi.arprot == 3'd0) && axi.rready;
                  len = int'(axi.arlen);
                  axi.arready = 1'b1;
                  phase = 1;
               end
            end else if (phase == 1) begin
               axi.arready = 1'b0;
               beat = 0;
               drive_beat(base, beat, len, err_beat, (ars == 1) && (beat == flush_beat));
               phase = 2;
            end else begin
               beat++;
               if (beat > len) begin
                  clear_bus();
                  phase = 0;
               end else begin
                  drive_beat(base, beat, len, err_beat, (ars == 1) && (beat == flush_beat));
               end
            end
         end
      end
      if (!got) begin
         n_vec++;
         n_fail++;
         $display("FAIL fetch_timeout: addr 0x%08h got no ready, required ready within 200 cycles", a);
      end
      @(posedge clk); #1;
      read_en = 1'b0;
      clear_bus();
   endtask

   task automatic run_vec(input vec_t v);
      logic got, e, fixed_ok;
      logic [31:0] d, ar_a;
      logic [7:0] ar_len;
      logic [2:0] ar_size;
      logic [1:0] ar_burst;
      int lat, ars;
      if (v.do_rst) apply_reset();
      fetch(v.a, v.unc, v.base, v.err_beat, v.flush_beat,
            got, d, e, lat, ars, ar_a, ar_len, ar_size, ar_burst, fixed_ok);
      check({v.name, ".ready"}, 32'(got), 32'd1);
      check({v.name, ".data"}, d, v.exp_data);
      check({v.name, ".error"}, 32'(e), 32'(v.exp_err));
      check({v.name, ".ar_count"}, 32'(ars), 32'(v.exp_ars));
      if (v.exp_ars > 0) begin
         check({v.name, ".araddr"}, ar_a, v.exp_araddr);
         check({v.name, ".arlen"}, 32'(ar_len), 32'(v.exp_arlen));
         check({v.name, ".arsize"}, 32'(ar_size), 32'd2);
         check({v.name, ".arburst"}, 32'(ar_burst), 32'd1);
         check({v.name, ".ar_consts"}, 32'(fixed_ok), 32'd1);
      end else begin
         check({v.name, ".latency"}, 32'(lat), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; read_en = 1'b0; uncached = 1'b0; addr = '0;
      clear_bus();

      vecs.push_back(mk("cold_1040",   1, 32'h0000_1040, 0, 32'h100, -1, -1, 0, 32'h100, 1, 32'h0000_1040, 8'd15));
      vecs.push_back(mk("hit_1044",    0, 32'h0000_1044, 0, 32'h0,   -1, -1, 0, 32'h101, 0, 32'h0, 8'd0));
      vecs.push_back(mk("hit_107c",    0, 32'h0000_107C, 0, 32'h0,   -1, -1, 0, 32'h10F, 0, 32'h0, 8'd0));
      vecs.push_back(mk("fill_2040",   0, 32'h0000_2040, 0, 32'h200, -1, -1, 0, 32'h200, 1, 32'h0000_2040, 8'd15));
      vecs.push_back(mk("hit_1048",    0, 32'h0000_1048, 0, 32'h0,   -1, -1, 0, 32'h102, 0, 32'h0, 8'd0));
      vecs.push_back(mk("hit_2044",    0, 32'h0000_2044, 0, 32'h0,   -1, -1, 0, 32'h201, 0, 32'h0, 8'd0));
      vecs.push_back(mk("evict_3040",  0, 32'h0000_3040, 0, 32'h300, -1, -1, 0, 32'h300, 1, 32'h0000_3040, 8'd15));
      vecs.push_back(mk("hit_3048",    0, 32'h0000_3048, 0, 32'h0,   -1, -1, 0, 32'h302, 0, 32'h0, 8'd0));
      vecs.push_back(mk("still_2044",  0, 32'h0000_2044, 0, 32'h0,   -1, -1, 0, 32'h201, 0, 32'h0, 8'd0));
      vecs.push_back(mk("miss_1040",   0, 32'h0000_1040, 0, 32'h400, -1, -1, 0, 32'h400, 1, 32'h0000_1040, 8'd15));
      vecs.push_back(mk("unc_boot",    1, 32'h1FC0_0004, 1, 32'hDEADBEEF, -1, -1, 0, 32'hDEADBEEF, 1, 32'h1FC0_0004, 8'd0));
      vecs.push_back(mk("cached_boot", 0, 32'h1FC0_0004, 0, 32'h500, -1, -1, 0, 32'h501, 1, 32'h1FC0_0000, 8'd15));
      vecs.push_back(mk("unc_unal",    0, 32'h0000_3006, 1, 32'h777, -1, -1, 0, 32'h777, 1, 32'h0000_3004, 8'd0));
      vecs.push_back(mk("cached_3004", 0, 32'h0000_3004, 0, 32'h800, -1, -1, 0, 32'h801, 1, 32'h0000_3000, 8'd15));
      vecs.push_back(mk("flush_b5",    1, 32'h0000_1040, 0, 32'h100, -1,  5, 0, 32'h100, 2, 32'h0000_1040, 8'd15));
      vecs.push_back(mk("err_b3",      1, 32'h0000_1040, 0, 32'h100,  3, -1, 1, 32'h0,   1, 32'h0000_1040, 8'd15));
      vecs.push_back(mk("after_err",   0, 32'h0000_1040, 0, 32'h900, -1, -1, 0, 32'h900, 1, 32'h0000_1040, 8'd15));
      vecs.push_back(mk("fill_2040b",  0, 32'h0000_2040, 0, 32'h200, -1, -1, 0, 32'h200, 1, 32'h0000_2040, 8'd15));

      // Reset values of every output.
      apply_reset();
      @(negedge clk);
      check("reset.ready", 32'(ready), 32'd0);
      check("reset.error", 32'(error), 32'd0);
      check("reset.data_out", data_out, 32'd0);
      check("reset.arvalid", 32'(axi.arvalid), 32'd0);
      check("reset.araddr", axi.araddr, 32'd0);
      check("reset.arlen", 32'(axi.arlen), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in the middle of a refill of 0x5040 (set 1, both ways valid).
      @(posedge clk); #1;
      read_en = 1'b1; addr = 32'h0000_5040; uncached = 1'b0;
      for (int k = 0; k < 20 && !axi.arvalid; k++) @(negedge clk);
      check("rst_seq.arvalid_before", 32'(axi.arvalid), 32'd1);
      axi.arready = 1'b1;
      @(negedge clk);
      axi.arready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         axi.rvalid = 1'b1; axi.rdata = 32'hA00 + 32'(b); axi.rlast = 1'b0; axi.rresp = 2'b00;
         @(negedge clk);
      end
      rst = 1'b1; read_en = 1'b0;
      @(negedge clk);
      check("rst_seq.arvalid", 32'(axi.arvalid), 32'd0);
      check("rst_seq.ready", 32'(ready), 32'd0);
      check("rst_seq.error", 32'(error), 32'd0);
      check("rst_seq.data_out", data_out, 32'd0);
      rst = 1'b0;
      clear_bus();
      run_vec(mk("rst_miss_2044", 0, 32'h0000_2044, 0, 32'h600, -1, -1, 0, 32'h601, 1, 32'h0000_2040, 8'd15));
      run_vec(mk("rst_miss_5040", 0, 32'h0000_5040, 0, 32'h700, -1, -1, 0, 32'h700, 1, 32'h0000_5040, 8'd15));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
